// File: rtl/ws2812b_multi_out.sv
// Multi-lane WS2812B serialiser: one shared bit-timing engine drives CHANNELS
// LED strings in lockstep, with a valid/ready pixel handshake and one latch
// gap per frame.
module ws2812b_multi_out #(
  parameter int CHANNELS   = 4,
  parameter int BITS       = 24,
  parameter int CYCLES_T0H = 4,
  parameter int CYCLES_T1H = 7,
  parameter int CYCLES_BIT = 11,
  parameter int CYCLES_RET = 450,
  parameter int CNT_WIDTH  = 9,
  parameter int INVERT     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_valid,
  input  logic [CHANNELS*BITS-1:0] pix_data,
  input  logic [CHANNELS-1:0]      chan_en,
  output logic                     pix_ready,
  output logic [CHANNELS-1:0]      ws_data,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int IDX_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CNT_WIDTH-1:0] PH_LAST  = CNT_WIDTH'(CYCLES_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] RET_LAST = CNT_WIDTH'(CYCLES_RET - 1);
  localparam logic [CNT_WIDTH-1:0] T0H      = CNT_WIDTH'(CYCLES_T0H);
  localparam logic [CNT_WIDTH-1:0] T1H      = CNT_WIDTH'(CYCLES_T1H);
  localparam logic [IDX_W-1:0]     IDX_TOP  = IDX_W'(BITS - 1);
  localparam logic                 INV      = (INVERT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT,
    S_LATCH
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       phase_q, phase_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CHANNELS*BITS-1:0]   shreg_q, shreg_d;
  logic [CHANNELS-1:0]        mask_q, mask_d;
  logic [CHANNELS-1:0]        ws_q, ws_d;
  logic                       done_q, done_d;
  logic                       xfer;
  logic                       lane_hi;

  // Handshake: ready in IDLE or on the very last cycle of the last bit.
  always_comb begin
    pix_ready = !reset &&
                ((state_q == S_IDLE) ||
                 ((state_q == S_BIT) && (phase_q == PH_LAST) && (idx_q == '0)));
    xfer      = pix_valid && pix_ready;
  end

  // Next-state logic; the phase counter doubles as the latch-gap counter.
  // Output levels are derived from the next-state values so ws_data is
  // registered yet rises the cycle right after the accept.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    ws_d    = '0;
    lane_hi = 1'b0;
    if (xfer) begin
      state_d = S_BIT;
      phase_d = '0;
      idx_d   = IDX_TOP;
      shreg_d = pix_data;
      mask_d  = chan_en;
    end else begin
      case (state_q)
        S_BIT: begin
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (idx_q == '0) begin
              state_d = S_LATCH;
            end else begin
              idx_d = idx_q - 1'b1;
              for (int unsigned c = 0; c < CHANNELS; c++) begin
                shreg_d[c*BITS +: BITS] = {shreg_q[c*BITS +: BITS-1], 1'b0};
              end
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        S_LATCH: begin
          if (phase_q == RET_LAST) begin
            state_d = S_IDLE;
            phase_d = '0;
            done_d  = 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      lane_hi = shreg_d[c*BITS + BITS - 1];
      ws_d[c] = INV ^ ((state_d == S_BIT) && mask_d[c] &&
                       (phase_d < (lane_hi ? T1H : T0H)));
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      mask_q  <= '0;
      ws_q    <= {CHANNELS{INV}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      mask_q  <= mask_d;
      ws_q    <= ws_d;
      done_q  <= done_d;
    end
  end

  assign ws_data    = ws_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812b_multi_out.sv
// Scoreboard bench: on every accepted pixel the reference model appends the
// full expected per-cycle trace (bits, latch gap, frame_done) to a queue; a
// negedge monitor pops one entry per cycle and compares.
module tb_ws2812b_multi_out;
  localparam int C    = 4;
  localparam int T0H  = 4;
  localparam int T1H  = 7;
  localparam int TBIT = 11;
  localparam int TRET = 450;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            r0, v0, rdy0, busy0, fd0;
  logic [C*24-1:0] d0;
  logic [C-1:0]    e0, ws0;
  logic            r1, v1, rdy1, busy1, fd1;
  logic [C*32-1:0] d1;
  logic [C-1:0]    e1, ws1;

  ws2812b_multi_out #(.CHANNELS(C), .BITS(24)) dut0 (
    .clk(clk), .reset(r0), .pix_valid(v0), .pix_data(d0), .chan_en(e0),
    .pix_ready(rdy0), .ws_data(ws0), .busy(busy0), .frame_done(fd0));

  ws2812b_multi_out #(.CHANNELS(C), .BITS(32), .INVERT(1)) dut1 (
    .clk(clk), .reset(r1), .pix_valid(v1), .pix_data(d1), .chan_en(e1),
    .pix_ready(rdy1), .ws_data(ws1), .busy(busy1), .frame_done(fd1));

  typedef struct packed {
    logic [C-1:0] ws;
    logic         busy;
    logic         fd;
    logic         rdy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  int   acc0   = 0;
  int   acc1   = 0;
  bit   mon_en = 1'b0;

  // Expected outputs t cycles after an accept (t=0 is the first bit cycle).
  function automatic exp_t pix_e(input logic [127:0] data, input logic [C-1:0] en,
                                 input int nb, input int t);
    exp_t e;
    int k, p, hi;
    k = t / TBIT;
    p = t % TBIT;
    e = '0;
    e.busy = 1'b1;
    e.rdy  = (t == nb*TBIT - 1);
    for (int c = 0; c < C; c++) begin
      hi = data[c*nb + nb - 1 - k] ? T1H : T0H;
      e.ws[c] = en[c] && (p < hi);
    end
    return e;
  endfunction

  function automatic void qpush(input int id, input exp_t e);
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic void frame_tail(input int id, input logic [127:0] data,
                                     input logic [C-1:0] en, input int nb);
    exp_t e;
    for (int t = 0; t < nb*TBIT; t++) qpush(id, pix_e(data, en, nb, t));
    e = '0; e.busy = 1'b1;
    for (int i = 0; i < TRET; i++) qpush(id, e);
    e = '0; e.fd = 1'b1; e.rdy = 1'b1;
    qpush(id, e);
  endfunction

  // Model step for the current cycle, then advance to the next one.
  task automatic commit();
    exp_t h;
    if (q0.size() == 0) begin h = '0; h.rdy = 1'b1; q0.push_back(h); end
    if (r0) begin
      h = q0[0]; h.rdy = 1'b0; q0.delete(); q0.push_back(h);
    end else if (v0 && q0[0].rdy) begin
      h = q0[0]; q0.delete(); q0.push_back(h);
      frame_tail(0, {32'b0, d0}, e0, 24);
      acc0++;
    end
    if (q1.size() == 0) begin h = '0; h.rdy = 1'b1; q1.push_back(h); end
    if (r1) begin
      h = q1[0]; h.rdy = 1'b0; q1.delete(); q1.push_back(h);
    end else if (v1 && q1[0].rdy) begin
      h = q1[0]; q1.delete(); q1.push_back(h);
      frame_tail(1, d1, e1, 32);
      acc1++;
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic send_pix(input int id, input logic [127:0] data, input logic [C-1:0] en);
    int start, g;
    g = 0;
    if (id == 0) begin v0 = 1'b1; d0 = data[95:0]; e0 = en; start = acc0; end
    else begin v1 = 1'b1; d1 = data; e1 = en; start = acc1; end
    while (((id == 0) ? acc0 : acc1) == start && g < 1000) begin commit(); g++; end
    checks++;
    if (((id == 0) ? acc0 : acc1) == start) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: no accept after %0d cycles, required accept", id, g);
    end
  endtask

  task automatic release_pix(input int id);
    if (id == 0) begin v0 = 1'b0; d0 = {$urandom, $urandom, $urandom}; e0 = 4'($urandom); end
    else begin v1 = 1'b0; d1 = {$urandom, $urandom, $urandom, $urandom}; e1 = 4'($urandom); end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((q0.size() > 1 || q1.size() > 1) && g < 5000) begin commit(); g++; end
    repeat (3) commit();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input int id, input exp_t act);
    exp_t e;
    checks++;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL sb_underflow dut%0d cycle %0d: no expected entry", id, cyc_n);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else e = q1.pop_front();
    if (act !== e) begin
      errors++;
      $display("FAIL trace dut%0d cycle %0d: got ws=%b busy=%b fd=%b rdy=%b, required ws=%b busy=%b fd=%b rdy=%b",
               id, cyc_n, act.ws, act.busy, act.fd, act.rdy, e.ws, e.busy, e.fd, e.rdy);
    end
  endtask

  // Monitor: one comparison per DUT per cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check(0, {ws0, busy0, fd0, rdy0});
      check(1, {ws1 ^ {C{1'b1}}, busy1, fd1, rdy1});
    end
  end

  initial begin
    r0 = 1'b1; r1 = 1'b1; v0 = 1'b0; v1 = 1'b0;
    d0 = '0; d1 = '0; e0 = '0; e1 = '0;
    repeat (3) @(posedge clk);
    #1;
    r0 = 1'b0; r1 = 1'b0;
    mon_en = 1'b1;
    repeat (4) commit();

    // Single known pixel on all four lanes.
    send_pix(0, {32'b0, 24'h800001, 24'h000000, 24'hFFFFFF, 24'hA50000}, 4'hF);
    release_pix(0);
    wait_idle();

    // Three back-to-back pixels with valid held high.
    for (int i = 0; i < 3; i++) send_pix(0, rnd128(), 4'hF);
    release_pix(0);
    wait_idle();

    // Disabled lanes stay low.
    send_pix(0, {32'b0, {4{24'hFFFFFF}}}, 4'b0101);
    release_pix(0);
    wait_idle();

    // Pixel offered at latch cycle 100 waits for the frame_done cycle.
    send_pix(0, rnd128(), 4'hF);
    release_pix(0);
    begin
      int g;
      g = 0;
      while (q0.size() > 351 && g < 2000) begin commit(); g++; end
    end
    send_pix(0, rnd128(), 4'hF);
    release_pix(0);
    wait_idle();

    // Reset in the middle of bit index 10; offer during reset is dropped.
    send_pix(0, rnd128(), 4'hF);
    repeat (148) commit();
    r0 = 1'b1; v0 = 1'b1; d0 = {$urandom, $urandom, $urandom};
    commit();
    r0 = 1'b0;
    send_pix(0, rnd128(), 4'($urandom));
    release_pix(0);
    wait_idle();

    // Random frames, random lane enables and gaps.
    for (int f = 0; f < 4; f++) begin
      int np;
      np = $urandom_range(1, 3);
      for (int i = 0; i < np; i++) send_pix(0, rnd128(), 4'($urandom));
      release_pix(0);
      wait_idle();
      repeat ($urandom_range(0, 5)) commit();
    end

    // Inverted 32-bit instance: single pixel 0x00000001 on lane 0.
    send_pix(1, {96'b0, 32'h00000001}, 4'b0001);
    release_pix(1);
    wait_idle();
    send_pix(1, rnd128(), 4'($urandom));
    send_pix(1, rnd128(), 4'($urandom));
    release_pix(1);
    wait_idle();

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812b_multi_out.md
Name: ws2812b_multi_out

Overview:
- Parametrised successor of the single-lane WS2812B serialiser. Drives CHANNELS independent LED strings in lockstep from one shared bit-timing engine.
- Configurable pixel width (24 RGB / 32 RGBW) and fully parametrised T0H/T1H/bit-period/latch timing.
- Uses a valid/ready pixel handshake with zero-gap back-to-back pixels.
- Issues a single latch gap per frame, then idles. It does not re-arm the latch endlessly.
- Sits between the frame-buffer reader and the output pins.

Parameters:
CHANNELS, 4, number of parallel LED strings
BITS, 24, bits per LED per channel (24 or 32), sent MSB first
CYCLES_T0H, 4, high time of a '0' bit in clk cycles (~0.44 us @ 9 MHz)
CYCLES_T1H, 7, high time of a '1' bit (~0.78 us @ 9 MHz)
CYCLES_BIT, 11, total bit period (~1.22 us @ 9 MHz)
CYCLES_RET, 450, low time of the latch/reset gap (50 us @ 9 MHz)
CNT_WIDTH, 9, counter width; must hold max(CYCLES_BIT, CYCLES_RET)
INVERT, 0, 1 = invert all ws_data outputs (inverting level shifter)
- Legal parameter set: 0 < CYCLES_T0H < CYCLES_T1H < CYCLES_BIT, and CYCLES_RET >= 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
pix_valid  in  1  pix_data/chan_en hold a pixel
pix_data  in  CHANNELS*BITS  channel c uses pix_data[c*BITS +: BITS]
chan_en  in  CHANNELS  per-channel enable, sampled with the pixel; a disabled lane stays low for that pixel
pix_ready  out  1  block accepts a pixel this cycle (combinational from state/counters)
ws_data  out  CHANNELS  registered serial lines
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse when a latch gap completes

Behaviour:
- States: IDLE, BIT, LATCH. All counters are unsigned CNT_WIDTH wide, plus a bit index of ceil(log2(BITS)) width.
- Transfer happens on pix_valid && pix_ready.
- pix_ready = 1 in IDLE.
- pix_ready = 1 in BIT only when phase == CYCLES_BIT-1 and bit index == 0 (last cycle of the last bit).
- pix_ready = 0 in LATCH and during reset.
- On transfer:
  - Capture pix_data into a shift register and chan_en into a mask.
  - Go to BIT with phase = 0 and bit index = BITS-1.
  - ws_data rises on the next cycle. Latency is accept cycle N to rising edge at N+1.
- In BIT, for each cycle with phase p:
  - Lane c is high iff mask[c] && p < (current bit of lane c ? CYCLES_T1H : CYCLES_T0H).
  - Otherwise lane c is low.
- Phase increments each cycle. At CYCLES_BIT-1 it wraps to 0, and the shift register advances by one bit per lane.
- One pixel occupies exactly BITS*CYCLES_BIT cycles.
- End of the last bit:
  - With a transfer: continue directly into the new pixel. There is no gap cycle.
  - Without a transfer: enter LATCH.
- LATCH:
  - All lanes are low for exactly CYCLES_RET cycles.
  - Then go to IDLE, with frame_done = 1 in the first IDLE cycle (registered pulse).
  - pix_valid asserted during LATCH is not accepted. It is accepted in the first IDLE cycle (same cycle as frame_done).
- IDLE: lanes stay low indefinitely. No repeated latch gaps.
- INVERT = 1 inverts only the final output register value. Every "high/low" above refers to logical level before inversion.
- Reset (any state, including mid-pixel or mid-latch):
  - Next cycle: state = IDLE, ws_data = all logical-low (all 1s if INVERT), busy = 0, frame_done = 0, shift register and mask cleared.
  - No latch gap is generated. Upstream restarts the frame.
- A pixel offered in the cycle reset is asserted is discarded.
- pix_data is not required to be stable after the accept cycle.

Test Plan:
- Single pixel, CHANNELS=4, BITS=24: lane0=0xA50000, lane1=0xFFFFFF, lane2=0x000000, lane3=0x800001, chan_en=0xF.
  - Required: lanes rise at N+1.
  - Bit k of each lane has high time 7 (for '1') or 4 (for '0') within an 11-cycle period.
  - 264 cycles later, a 450-cycle low gap, then a frame_done pulse.
- Three pixels, pix_valid held high.
  - Required: pix_ready only on the 264-cycle boundaries.
  - Rising edges of consecutive pixels are exactly 11 cycles apart across the boundary.
  - Exactly one latch gap after the third pixel.
- chan_en=0b0101, all data 0xFFFFFF.
  - Required: lanes 1 and 3 are constant low.
  - Lanes 0 and 2 show 24 pulses of 7 cycles.
- pix_valid asserted at cycle 100 of LATCH.
  - Required: pix_ready=0 until LATCH ends.
  - Accepted in the frame_done cycle; lanes rise one cycle later.
- Reset asserted mid-bit 10 of a pixel.
  - Required: next cycle all lanes low, busy=0, no frame_done.
  - A new pixel is accepted the cycle after reset deasserts.
- INVERT=1, BITS=32, one pixel 0x00000001 on lane0.
  - Required: idle level is 1.
  - Bits 31..1 are low-going pulses of 4 cycles; bit 0 is a low-going pulse of 7 cycles.
  - Then a 450-cycle high gap.
